// File: rtl/shift_issue_stage.sv
// shift_issue_stage: decodes LSHI/LSH/LUI into shifter operands behind a 2-entry skid buffer.
// Optional perf counters (perf_issued, perf_stall) are enabled by defining SHIFT_ISSUE_PERF_EN.
module shift_issue_stage #(
  parameter int WIDTH      = 16,
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [15:0]           in_instr,
  input  logic [WIDTH-1:0]      in_rsrc_val,
  input  logic [WIDTH-1:0]      in_rdst_val,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3:0]            out_opcode,
  output logic [3:0]            out_shamt,
  output logic [WIDTH-1:0]      out_srca,
  output logic [WIDTH-1:0]      out_srcb,
  output logic [REG_ADDR_W-1:0] out_rdest,
`ifdef SHIFT_ISSUE_PERF_EN
  output logic [15:0]           perf_issued,
  output logic [15:0]           perf_stall,
`endif
  output logic                  out_illegal
);

  typedef struct packed {
    logic [3:0]            opcode;
    logic [3:0]            shamt;
    logic [WIDTH-1:0]      srca;
    logic [WIDTH-1:0]      srcb;
    logic [REG_ADDR_W-1:0] rdest;
    logic                  illegal;
  } op_t;

  op_t  dec;
  op_t  main_q, main_d;
  op_t  skid_q, skid_d;
  logic main_vld_q, main_vld_d;
  logic skid_vld_q, skid_vld_d;
  logic accept;
  logic is_lshi, is_lsh, is_lui;

  assign is_lshi = (in_instr[15:12] == 4'h8) && (in_instr[7:5] == 3'b000);
  assign is_lsh  = (in_instr[15:12] == 4'h8) && (in_instr[7:4] == 4'h4);
  assign is_lui  = (in_instr[15:12] == 4'hF);

  // Decode the incoming instruction into shifter operands.
  always_comb begin
    dec         = '0;
    dec.srca    = in_rdst_val;
    dec.srcb    = in_rsrc_val;
    dec.rdest   = REG_ADDR_W'(in_instr[11:8]);
    unique case (1'b1)
      is_lshi: begin
        dec.opcode = {3'b000, in_instr[4]};
        dec.shamt  = in_instr[3:0];
      end
      is_lsh: begin
        dec.opcode = 4'h4;
      end
      is_lui: begin
        dec.opcode = 4'hF;
        dec.srcb   = {{(WIDTH-8){1'b0}}, in_instr[7:0]};
      end
      default: begin
        dec.opcode  = 4'h2;
        dec.illegal = 1'b1;
      end
    endcase
  end

  assign in_ready = ~skid_vld_q;
  assign accept   = in_valid & in_ready & ~flush;

  // Main/skid next state: skid drains first, so order is kept.
  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!main_vld_q || out_ready) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else begin
        if (accept) main_d = dec;
        main_vld_d = accept;
      end
    end else if (accept) begin
      skid_d     = dec;
      skid_vld_d = 1'b1;
    end
  end

  // Pipeline registers; async reset clears valids and output data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  assign out_valid   = main_vld_q;
  assign out_opcode  = main_q.opcode;
  assign out_shamt   = main_q.shamt;
  assign out_srca    = main_q.srca;
  assign out_srcb    = main_q.srcb;
  assign out_rdest   = main_q.rdest;
  assign out_illegal = main_q.illegal;

`ifdef SHIFT_ISSUE_PERF_EN
  logic [15:0] issued_q, stall_q;

  // Issue and stall counters; they survive flush and wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issued_q <= '0;
      stall_q  <= '0;
    end else begin
      if (main_vld_q && out_ready)  issued_q <= issued_q + 16'd1;
      if (main_vld_q && !out_ready) stall_q  <= stall_q + 16'd1;
    end
  end

  assign perf_issued = issued_q;
  assign perf_stall  = stall_q;
`endif

endmodule

// File: tb/tb_shift_issue_stage.sv
// Directed bench for shift_issue_stage: decode vectors, skid ordering,
// flush, reset mid-stall and (with SHIFT_ISSUE_PERF_EN) perf counters.
module tb_shift_issue_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic [15:0] in_rsrc_val;
  logic [15:0] in_rdst_val;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_opcode;
  logic [3:0]  out_shamt;
  logic [15:0] out_srca;
  logic [15:0] out_srcb;
  logic [3:0]  out_rdest;
  logic        out_illegal;
`ifdef SHIFT_ISSUE_PERF_EN
  logic [15:0] perf_issued;
  logic [15:0] perf_stall;
`endif

  int checks = 0;
  int errors = 0;

  shift_issue_stage #(.WIDTH(16), .REG_ADDR_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_rsrc_val (in_rsrc_val),
    .in_rdst_val (in_rdst_val),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_opcode  (out_opcode),
    .out_shamt   (out_shamt),
    .out_srca    (out_srca),
    .out_srcb    (out_srcb),
    .out_rdest   (out_rdest),
`ifdef SHIFT_ISSUE_PERF_EN
    .perf_issued (perf_issued),
    .perf_stall  (perf_stall),
`endif
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one rising edge, then back to the falling edge for drive/sample
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [15:0] ins, input logic [15:0] rs,
                       input logic [15:0] rd);
    in_valid    = 1'b1;
    in_instr    = ins;
    in_rsrc_val = rs;
    in_rdst_val = rd;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_rsrc_val = '0; in_rdst_val = '0;
    #12;
    chk("rst_valid",  {31'b0, out_valid}, 32'd0);
    chk("rst_ready",  {31'b0, in_ready}, 32'd1);
    chk("rst_opcode", {28'b0, out_opcode}, 32'd0);
    chk("rst_srca",   {16'b0, out_srca}, 32'd0);
    chk("rst_srcb",   {16'b0, out_srcb}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // LSHI left
    drive(16'h8305, 16'h5555, 16'h1234); tick();
    chk("lshl_valid",  {31'b0, out_valid}, 32'd1);
    chk("lshl_opcode", {28'b0, out_opcode}, 32'h0);
    chk("lshl_shamt",  {28'b0, out_shamt}, 32'h5);
    chk("lshl_srca",   {16'b0, out_srca}, 32'h1234);
    chk("lshl_srcb",   {16'b0, out_srcb}, 32'h5555);
    chk("lshl_rdest",  {28'b0, out_rdest}, 32'h3);
    chk("lshl_ill",    {31'b0, out_illegal}, 32'd0);
    // LSHI right
    drive(16'h8315, 16'h0001, 16'h00FF); tick();
    chk("lshr_opcode", {28'b0, out_opcode}, 32'h1);
    chk("lshr_shamt",  {28'b0, out_shamt}, 32'h5);
    chk("lshr_srca",   {16'b0, out_srca}, 32'h00FF);
    // LSH
    drive(16'h8247, 16'h0009, 16'hBEEF); tick();
    chk("lsh_opcode", {28'b0, out_opcode}, 32'h4);
    chk("lsh_shamt",  {28'b0, out_shamt}, 32'h0);
    chk("lsh_srcb",   {16'b0, out_srcb}, 32'h0009);
    chk("lsh_rdest",  {28'b0, out_rdest}, 32'h2);
    // LUI
    drive(16'hF1AB, 16'hFFFF, 16'h0000); tick();
    chk("lui_opcode", {28'b0, out_opcode}, 32'hF);
    chk("lui_srcb",   {16'b0, out_srcb}, 32'h00AB);
    chk("lui_rdest",  {28'b0, out_rdest}, 32'h1);
    chk("lui_shamt",  {28'b0, out_shamt}, 32'h0);
    // non-shift
    drive(16'h0123, 16'h7777, 16'h0000); tick();
    chk("ill_opcode", {28'b0, out_opcode}, 32'h2);
    chk("ill_flag",   {31'b0, out_illegal}, 32'd1);
    chk("ill_srcb",   {16'b0, out_srcb}, 32'h7777);
    // opcode 8 with instr[7:4]=5: neither LSHI nor LSH
    drive(16'h8355, 16'h0000, 16'h0000); tick();
    chk("x8_opcode", {28'b0, out_opcode}, 32'h2);
    chk("x8_flag",   {31'b0, out_illegal}, 32'd1);
    chk("x8_shamt",  {28'b0, out_shamt}, 32'h0);
    in_valid = 1'b0; tick();
    chk("idle_valid", {31'b0, out_valid}, 32'd0);

    // backpressure: A held, B in skid, C blocked
    out_ready = 1'b0;
    drive(16'h8301, 16'h0, 16'h000A); tick();
    chk("bp_a_valid", {31'b0, out_valid}, 32'd1);
    chk("bp_ready1",  {31'b0, in_ready}, 32'd1);
    drive(16'h8302, 16'h0, 16'h000B); tick();
    chk("bp_a_held",  {16'b0, out_srca}, 32'h000A);
    chk("bp_ready0",  {31'b0, in_ready}, 32'd0);
    drive(16'h8303, 16'h0, 16'h000C); tick();
    chk("bp_a_held2", {16'b0, out_srca}, 32'h000A);
    chk("bp_a_shamt", {28'b0, out_shamt}, 32'h1);
    chk("bp_blockC",  {31'b0, in_ready}, 32'd0);
    out_ready = 1'b1; tick();
    chk("bp_b_out",   {16'b0, out_srca}, 32'h000B);
    chk("bp_b_shamt", {28'b0, out_shamt}, 32'h2);
    chk("bp_ready2",  {31'b0, in_ready}, 32'd1);
    tick();
    chk("bp_c_out",   {16'b0, out_srca}, 32'h000C);
    chk("bp_c_valid", {31'b0, out_valid}, 32'd1);
    in_valid = 1'b0; tick();
    chk("bp_drained", {31'b0, out_valid}, 32'd0);

    // flush with main and skid full, beat presented during flush
    out_ready = 1'b0;
    drive(16'h8301, 16'h0, 16'h0011); tick();
    drive(16'h8302, 16'h0, 16'h0022); tick();
    chk("fl_full", {31'b0, in_ready}, 32'd0);
    flush = 1'b1;
    drive(16'h8303, 16'h0, 16'h0033); tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", {31'b0, out_valid}, 32'd0);
    chk("fl_ready", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b1; tick();
    chk("fl_empty", {31'b0, out_valid}, 32'd0);
    // flush with in_ready=1 drops the beat
    flush = 1'b1;
    drive(16'h8305, 16'h0, 16'h0044); tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_drop", {31'b0, out_valid}, 32'd0);
    tick();
    chk("fl_drop2", {31'b0, out_valid}, 32'd0);

    // reset asserted mid-stall
    out_ready = 1'b0;
    drive(16'hF1AB, 16'h0, 16'h5A5A); tick();
    drive(16'h8315, 16'h0, 16'hA5A5); tick();
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rs_valid",  {31'b0, out_valid}, 32'd0);
    chk("rs_ready",  {31'b0, in_ready}, 32'd1);
    chk("rs_opcode", {28'b0, out_opcode}, 32'd0);
    chk("rs_srca",   {16'b0, out_srca}, 32'd0);
    chk("rs_srcb",   {16'b0, out_srcb}, 32'd0);
    chk("rs_rdest",  {28'b0, out_rdest}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
`ifdef SHIFT_ISSUE_PERF_EN
    chk("pf_iss0", {16'b0, perf_issued}, 32'd0);
    chk("pf_stl0", {16'b0, perf_stall}, 32'd0);
`endif

    // 4 issues then 2 stall cycles
    out_ready = 1'b1;
    drive(16'h8301, 16'h0, 16'h0001); tick();
    drive(16'h8302, 16'h0, 16'h0002); tick();
    drive(16'h8303, 16'h0, 16'h0003); tick();
    drive(16'h8304, 16'h0, 16'h0004); tick();
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    chk("pf_hold", {16'b0, out_srca}, 32'h0004);
    out_ready = 1'b1; tick();
    chk("pf_done", {31'b0, out_valid}, 32'd0);
`ifdef SHIFT_ISSUE_PERF_EN
    chk("pf_issued", {16'b0, perf_issued}, 32'd4);
    chk("pf_stall",  {16'b0, perf_stall}, 32'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
